// File: rtl/baccarat_pkg.sv
// Shared types and scoring rules for the baccarat round sequencer.
// Holds the FSM state encoding, card/score value helpers and the banker third-card table.
package baccarat_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CLR    = 4'd1,
      S_P1     = 4'd2,
      S_D1     = 4'd3,
      S_P2     = 4'd4,
      S_D2     = 4'd5,
      S_EVAL   = 4'd6,
      S_P3     = 4'd7,
      S_BCHK   = 4'd8,
      S_D3     = 4'd9,
      S_RESULT = 4'd10,
      S_NEXT   = 4'd11,
      S_DONE   = 4'd12
   } state_t;

   localparam logic [3:0] NATURAL_MIN      = 4'd8;
   localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
   localparam logic [3:0] BANKER_STAND_MIN = 4'd6;

   // Face cards and tens count as zero; out-of-range ranks are treated the same way.
   function automatic logic [3:0] card_value(input logic [3:0] rank);
      logic [3:0] v;
      if ((rank >= 4'd1) && (rank <= 4'd9)) begin
         v = rank;
      end else begin
         v = 4'd0;
      end
      return v;
   endfunction

   function automatic logic [3:0] score_value(input logic [3:0] score);
      logic [3:0] v;
      if (score <= 4'd9) begin
         v = score;
      end else begin
         v = 4'd0;
      end
      return v;
   endfunction

   function automatic logic banker_draws(input logic [3:0] dscore, input logic [3:0] v);
      logic draw;
      case (dscore)
         4'd0, 4'd1, 4'd2: draw = 1'b1;
         4'd3:             draw = (v != 4'd8);
         4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
         4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
         4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
         default:          draw = 1'b0;
      endcase
      return draw;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over enable.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clear,
   input  logic         i_en,
   output logic [W-1:0] o_q
);

   localparam logic [W-1:0] MAX_Q = {W{1'b1}};

   logic [W-1:0] r_q;

   // count register, sticks at all-ones
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q <= '0;
      end else if (i_clear) begin
         r_q <= '0;
      end else if (i_en && (r_q != MAX_Q)) begin
         r_q <= r_q + W'(1'b1);
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Hand/session sequencer for the baccarat datapath: deals cards via one-cycle strobes,
// applies natural and third-card rules, latches winner lights and keeps saturating tallies.
module baccarat_round_ctrl
   import baccarat_pkg::*;
#(
   parameter int ROUNDS  = 8,
   parameter int TALLY_W = 4
) (
   input  logic                       i_slow_clock,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic                       i_pause,
   input  logic [3:0]                 i_pscore,
   input  logic [3:0]                 i_dscore,
   input  logic [3:0]                 i_pcard3,
   output logic                       o_clear_hand,
   output logic                       o_load_pcard1,
   output logic                       o_load_pcard2,
   output logic                       o_load_pcard3,
   output logic                       o_load_dcard1,
   output logic                       o_load_dcard2,
   output logic                       o_load_dcard3,
   output logic                       o_player_win,
   output logic                       o_dealer_win,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [$clog2(ROUNDS+1)-1:0] o_round_idx,
   output logic [TALLY_W-1:0]         o_pwins,
   output logic [TALLY_W-1:0]         o_dwins,
   output logic [TALLY_W-1:0]         o_ties
);

   localparam int               IDX_W    = $clog2(ROUNDS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       w_p;
   logic [3:0]       w_d;
   logic [3:0]       w_v;
   logic             w_run;
   logic             w_go;
   logic             w_result_exit;
   logic             w_next_exit;
   logic             w_strobe_en;
   logic [IDX_W-1:0] r_round_idx;
   logic [IDX_W-1:0] w_idx_inc;
   logic             r_player_win;
   logic             r_dealer_win;

   assign w_p           = score_value(i_pscore);
   assign w_d           = score_value(i_dscore);
   assign w_v           = card_value(i_pcard3);
   assign w_run         = !i_pause;
   assign w_go          = w_run && i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_result_exit = w_run && (r_state == S_RESULT);
   assign w_next_exit   = w_run && (r_state == S_NEXT);
   assign w_idx_inc     = r_round_idx + IDX_W'(1'b1);

   // state register; pause freezes the sequencer in place
   always_ff @(posedge i_slow_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else if (w_run) begin
         r_state <= w_next;
      end else begin
         r_state <= r_state;
      end
   end

   // next-state rules for dealing, drawing and session progress
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_next = S_CLR;
            end else begin
               w_next = r_state;
            end
         end
         S_CLR:  w_next = S_P1;
         S_P1:   w_next = S_D1;
         S_D1:   w_next = S_P2;
         S_P2:   w_next = S_D2;
         S_D2:   w_next = S_EVAL;
         S_EVAL: begin
            if ((w_p >= NATURAL_MIN) || (w_d >= NATURAL_MIN)) begin
               w_next = S_RESULT;
            end else if (w_p < PLAYER_STAND_MIN) begin
               w_next = S_P3;
            end else if (w_d < BANKER_STAND_MIN) begin
               w_next = S_D3;
            end else begin
               w_next = S_RESULT;
            end
         end
         S_P3:   w_next = S_BCHK;
         S_BCHK: begin
            if (banker_draws(w_d, w_v)) begin
               w_next = S_D3;
            end else begin
               w_next = S_RESULT;
            end
         end
         S_D3:     w_next = S_RESULT;
         S_RESULT: w_next = S_NEXT;
         S_NEXT: begin
            if (w_idx_inc == LAST_IDX) begin
               w_next = S_DONE;
            end else begin
               w_next = S_CLR;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Moore strobe decode; a paused or resetting cycle never loads a card
   always_comb begin
      w_strobe_en   = w_run && !i_reset;
      o_clear_hand  = 1'b0;
      o_load_pcard1 = 1'b0;
      o_load_pcard2 = 1'b0;
      o_load_pcard3 = 1'b0;
      o_load_dcard1 = 1'b0;
      o_load_dcard2 = 1'b0;
      o_load_dcard3 = 1'b0;
      case (r_state)
         S_CLR:   o_clear_hand  = w_strobe_en;
         S_P1:    o_load_pcard1 = w_strobe_en;
         S_D1:    o_load_dcard1 = w_strobe_en;
         S_P2:    o_load_pcard2 = w_strobe_en;
         S_D2:    o_load_dcard2 = w_strobe_en;
         S_P3:    o_load_pcard3 = w_strobe_en;
         S_D3:    o_load_dcard3 = w_strobe_en;
         default: o_clear_hand  = 1'b0;
      endcase
      o_busy = (r_state != S_IDLE) && (r_state != S_DONE);
      o_done = (r_state == S_DONE);
   end

   // winner lights: both set on a tie, held until the next result or restart
   always_ff @(posedge i_slow_clock) begin
      if (i_reset) begin
         r_player_win <= 1'b0;
         r_dealer_win <= 1'b0;
      end else if (w_go) begin
         r_player_win <= 1'b0;
         r_dealer_win <= 1'b0;
      end else if (w_result_exit) begin
         r_player_win <= (w_p >= w_d);
         r_dealer_win <= (w_d >= w_p);
      end else begin
         r_player_win <= r_player_win;
         r_dealer_win <= r_dealer_win;
      end
   end

   // completed-hand counter for the session
   always_ff @(posedge i_slow_clock) begin
      if (i_reset) begin
         r_round_idx <= '0;
      end else if (w_go) begin
         r_round_idx <= '0;
      end else if (w_next_exit) begin
         r_round_idx <= w_idx_inc;
      end else begin
         r_round_idx <= r_round_idx;
      end
   end

   sat_counter #(.W(TALLY_W)) u_pwins (
      .i_clk   (i_slow_clock),
      .i_reset (i_reset),
      .i_clear (w_go),
      .i_en    (w_result_exit && (w_p > w_d)),
      .o_q     (o_pwins)
   );

   sat_counter #(.W(TALLY_W)) u_dwins (
      .i_clk   (i_slow_clock),
      .i_reset (i_reset),
      .i_clear (w_go),
      .i_en    (w_result_exit && (w_d > w_p)),
      .o_q     (o_dwins)
   );

   sat_counter #(.W(TALLY_W)) u_ties (
      .i_clk   (i_slow_clock),
      .i_reset (i_reset),
      .i_clear (w_go),
      .i_en    (w_result_exit && (w_p == w_d)),
      .o_q     (o_ties)
   );

   assign o_player_win = r_player_win;
   assign o_dealer_win = r_dealer_win;
   assign o_round_idx  = r_round_idx;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Scoreboard bench for baccarat_round_ctrl: a datapath model feeds scores on the load strobes,
// a monitor measures each hand and compares it against queued hand-computed expectations.
module tb_baccarat_round_ctrl;

   typedef struct {
      logic [3:0] p2;
      logic [3:0] d2;
      logic [3:0] rank;
      logic [3:0] p3;
      logic [3:0] d3;
   } hand_t;

   typedef struct {
      int cyc;
      int n_p3;
      int n_d3;
      int pwin;
      int dwin;
      int done;
      int idx;
      int pw;
      int dw;
      int ti;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       pause;
   logic       start_b;
   logic [3:0] pscore;
   logic [3:0] dscore;
   logic [3:0] pcard3;

   logic       clear_hand, load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic       player_win, dealer_win, busy, done;
   logic [1:0] round_idx;
   logic [3:0] pwins, dwins, ties;

   logic       b_clear_hand, b_load_pcard1, b_load_pcard2, b_load_pcard3;
   logic       b_load_dcard1, b_load_dcard2, b_load_dcard3;
   logic       b_player_win, b_dealer_win, b_busy, b_done;
   logic [3:0] b_round_idx;
   logic [1:0] b_pwins, b_dwins, b_ties;

   hand_t hand_q[$];
   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   always #5 clk = ~clk;

   baccarat_round_ctrl #(.ROUNDS(3), .TALLY_W(4)) dut (
      .i_slow_clock (clk),
      .i_reset      (reset),
      .i_start      (start),
      .i_pause      (pause),
      .i_pscore     (pscore),
      .i_dscore     (dscore),
      .i_pcard3     (pcard3),
      .o_clear_hand (clear_hand),
      .o_load_pcard1(load_pcard1),
      .o_load_pcard2(load_pcard2),
      .o_load_pcard3(load_pcard3),
      .o_load_dcard1(load_dcard1),
      .o_load_dcard2(load_dcard2),
      .o_load_dcard3(load_dcard3),
      .o_player_win (player_win),
      .o_dealer_win (dealer_win),
      .o_busy       (busy),
      .o_done       (done),
      .o_round_idx  (round_idx),
      .o_pwins      (pwins),
      .o_dwins      (dwins),
      .o_ties       (ties)
   );

   // second instance: every hand a player natural, to push a 2-bit tally into saturation
   baccarat_round_ctrl #(.ROUNDS(8), .TALLY_W(2)) dut_sat (
      .i_slow_clock (clk),
      .i_reset      (reset),
      .i_start      (start_b),
      .i_pause      (1'b0),
      .i_pscore     (4'd9),
      .i_dscore     (4'd0),
      .i_pcard3     (4'd0),
      .o_clear_hand (b_clear_hand),
      .o_load_pcard1(b_load_pcard1),
      .o_load_pcard2(b_load_pcard2),
      .o_load_pcard3(b_load_pcard3),
      .o_load_dcard1(b_load_dcard1),
      .o_load_dcard2(b_load_dcard2),
      .o_load_dcard3(b_load_dcard3),
      .o_player_win (b_player_win),
      .o_dealer_win (b_dealer_win),
      .o_busy       (b_busy),
      .o_done       (b_done),
      .o_round_idx  (b_round_idx),
      .o_pwins      (b_pwins),
      .o_dwins      (b_dwins),
      .o_ties       (b_ties)
   );

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      logic [24:0] v;
      v = {clear_hand, load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
           load_dcard3, player_win, dealer_win, busy, done, round_idx, pwins, dwins, ties};
      check(name, int'(v), 0);
   endtask

   task automatic push_hand(input logic [3:0] p2, input logic [3:0] d2, input logic [3:0] rank,
                            input logic [3:0] p3, input logic [3:0] d3,
                            input int cyc, input int n_p3, input int n_d3,
                            input int pwin, input int dwin, input int dn, input int idx,
                            input int pw, input int dw, input int ti);
      hand_t h;
      exp_t  e;
      h.p2 = p2; h.d2 = d2; h.rank = rank; h.p3 = p3; h.d3 = d3;
      e.cyc = cyc; e.n_p3 = n_p3; e.n_d3 = n_d3; e.pwin = pwin; e.dwin = dwin;
      e.done = dn; e.idx = idx; e.pw = pw; e.dw = dw; e.ti = ti;
      hand_q.push_back(h);
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; (i < 300) && !done; i++) begin
         tick();
      end
      check(name, int'(done), 1);
   endtask

   // datapath model: scores change when the matching strobe is seen
   initial begin : datapath
      hand_t cur;
      cur.p2 = 4'd0; cur.d2 = 4'd0; cur.rank = 4'd0; cur.p3 = 4'd0; cur.d3 = 4'd0;
      pscore = 4'd0;
      dscore = 4'd0;
      pcard3 = 4'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pscore = 4'd0;
            dscore = 4'd0;
            pcard3 = 4'd0;
         end else begin
            if (clear_hand) begin
               pscore = 4'd0;
               dscore = 4'd0;
               pcard3 = 4'd0;
               if (hand_q.size() > 0) cur = hand_q.pop_front();
            end
            if (load_dcard2) begin
               pscore = cur.p2;
               dscore = cur.d2;
            end
            if (load_pcard3) begin
               pscore = cur.p3;
               pcard3 = cur.rank;
            end
            if (load_dcard3) dscore = cur.d3;
         end
      end
   end

   // monitor: a hand ends at the next clear_hand or when busy drops
   initial begin : monitor
      bit   in_hand;
      int   cyc, np1, np3, nd3;
      exp_t e;
      in_hand = 1'b0;
      cyc = 0; np1 = 0; np3 = 0; nd3 = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_hand = 1'b0;
         end else begin
            if (in_hand && (clear_hand || !busy)) begin
               in_hand = 1'b0;
               check("hand_expected", exp_q.size() > 0 ? 1 : 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("hand_cycles", cyc, e.cyc);
                  check("pcard1_pulses", np1, 1);
                  check("pcard3_pulses", np3, e.n_p3);
                  check("dcard3_pulses", nd3, e.n_d3);
                  check("player_win", int'(player_win), e.pwin);
                  check("dealer_win", int'(dealer_win), e.dwin);
                  check("done_after_hand", int'(done), e.done);
                  check("round_idx", int'(round_idx), e.idx);
                  check("pwins", int'(pwins), e.pw);
                  check("dwins", int'(dwins), e.dw);
                  check("ties", int'(ties), e.ti);
               end
            end
            if (clear_hand) begin
               in_hand = 1'b1;
               cyc = 0; np1 = 0; np3 = 0; nd3 = 0;
            end
            if (in_hand && busy && !pause) begin
               cyc++;
               np1 += int'(load_pcard1);
               np3 += int'(load_pcard3);
               nd3 += int'(load_dcard3);
            end
         end
      end
   end

   initial begin : stimulus
      reset   = 1'b1;
      start   = 1'b0;
      pause   = 1'b0;
      start_b = 1'b0;
      tick();
      tick();
      check_idle("reset_state");
      reset = 1'b0;
      tick();

      // session 1: natural, player draws/banker stands, both draw
      push_hand(4'd8, 4'd4, 4'd0,  4'd0, 4'd0, 8,  0, 0, 1, 0, 0, 1, 1, 0, 0);
      push_hand(4'd3, 4'd4, 4'd13, 4'd3, 4'd0, 10, 1, 0, 0, 1, 0, 2, 1, 1, 0);
      push_hand(4'd3, 4'd4, 4'd5,  4'd8, 4'd7, 11, 1, 1, 1, 0, 1, 3, 2, 1, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      pause = 1'b1;
      repeat (4) tick();
      pause = 1'b0;
      repeat (8) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("session1_done");
      check("session1_round_idx", int'(round_idx), 3);
      check("session1_busy", int'(busy), 0);
      repeat (3) tick();
      check("done_held", int'(done), 1);

      // session 2 restarts from DONE: banker-only draw tie, stand/stand tie, both draw
      push_hand(4'd6, 4'd5, 4'd0, 4'd0, 4'd6, 9,  0, 1, 1, 1, 0, 1, 0, 0, 1);
      push_hand(4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 8,  0, 0, 1, 1, 0, 2, 0, 0, 2);
      push_hand(4'd2, 4'd6, 4'd7, 4'd9, 4'd8, 11, 1, 1, 1, 0, 1, 3, 1, 0, 2);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("session2_done");
      check("session2_round_idx", int'(round_idx), 3);

      // reset in P2 with start held high
      hand_q.push_back('{4'd2, 4'd2, 4'd1, 4'd3, 4'd2});
      start = 1'b1;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      check_idle("reset_mid_hand");
      repeat (3) begin
         tick();
         check_idle("reset_hold");
      end
      start = 1'b0;
      reset = 1'b0;
      tick();
      check_idle("after_reset");

      // saturation on the 2-bit tally instance
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; (i < 300) && (b_round_idx != 4'd5); i++) begin
         tick();
      end
      check("sat_rounds", int'(b_round_idx), 5);
      check("sat_pwins", int'(b_pwins), 3);
      check("sat_dwins", int'(b_dwins), 0);
      check("sat_player_flag", int'(b_player_win), 1);
      check("sat_dealer_flag", int'(b_dealer_win), 0);

      repeat (2) tick();
      check("exp_queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
